// File: rtl/sec_fnd_drv_pkg.sv
// Shared definitions for the seconds display driver: FSM encoding, segment
// patterns and the double-dabble step used by the binary-to-BCD converter.
package sec_fnd_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam logic [3:0] BCD_OOR   = 4'hF;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9
    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };

    localparam int SHIFT_STEPS = 6;

    // One double-dabble step on {tens, ones, binary[5:0]}: add 3 to any
    // BCD digit >= 5, then shift the whole register left by one.
    function automatic logic [13:0] dabble_step(input logic [13:0] s);
        logic [13:0] t;
        t = s;
        if (t[9:6] >= 4'd5)
            t[9:6] = t[9:6] + 4'd3;
        if (t[13:10] >= 4'd5)
            t[13:10] = t[13:10] + 4'd3;
        return {t[12:0], 1'b0};
    endfunction

endpackage

// File: rtl/sec_fnd_drv_bcd2seg.sv
// Combinational BCD to active-low 7-segment decoder with dash for the
// out-of-range marker and blank for any other non-decimal code.
module bcd2seg
    import sec_fnd_drv_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9)
            seg = SEG_TABLE[bcd];
        else if (bcd == BCD_OOR)
            seg = SEG_DASH;
    end

endmodule

// File: rtl/sec_fnd_drv.sv
// Seconds display driver: converts a 0..59 binary value to BCD with a
// multi-cycle double-dabble FSM and scans two common-anode digits.
module sec_fnd_drv
    import sec_fnd_drv_pkg::*;
#(
    parameter logic [15:0] SCAN_DIV = 16'd50000,
    parameter bit          LZ_BLANK = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] in_val,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       conv_busy,
    output logic [6:0] fnd_seg,
    output logic [1:0] fnd_com
);

    conv_state_t state;
    logic [2:0]  step_cnt;
    logic [13:0] shift_reg;
    logic [5:0]  val_q;
    logic        conv_pend;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            step_cnt  <= 3'd0;
            shift_reg <= 14'd0;
            val_q     <= 6'd0;
            conv_pend <= 1'b1;
            bcd_tens  <= 4'd0;
            bcd_ones  <= 4'd0;
            conv_busy <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_val != val_q || conv_pend) begin
                        val_q     <= in_val;
                        shift_reg <= {8'd0, in_val};
                        conv_pend <= 1'b0;
                        step_cnt  <= 3'd0;
                        conv_busy <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_reg <= dabble_step(shift_reg);
                    step_cnt  <= step_cnt + 3'd1;
                    if (step_cnt == 3'(SHIFT_STEPS - 1))
                        state <= ST_DONE;
                end
                ST_DONE: begin
                    // bcd outputs only change here, so an aborted conversion never leaks
                    if (val_q >= 6'd60) begin
                        bcd_tens <= BCD_OOR;
                        bcd_ones <= BCD_OOR;
                    end else begin
                        bcd_tens <= shift_reg[13:10];
                        bcd_ones <= shift_reg[9:6];
                    end
                    conv_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    conv_busy <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    logic [15:0] presc;
    logic        dig_sel;   // 0 = ones slot, 1 = tens slot
    logic [3:0]  digit;
    logic [6:0]  seg_raw;
    logic [6:0]  seg_next;

    assign digit = dig_sel ? bcd_tens : bcd_ones;

    bcd2seg u_bcd2seg (
        .bcd (digit),
        .seg (seg_raw)
    );

    assign seg_next = (LZ_BLANK && dig_sel && bcd_tens == 4'd0) ? SEG_BLANK : seg_raw;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= 16'd0;
            dig_sel <= 1'b0;
            fnd_com <= 2'b11;
            fnd_seg <= SEG_BLANK;
        end else begin
            if (presc == SCAN_DIV - 16'd1) begin
                presc   <= 16'd0;
                dig_sel <= ~dig_sel;
            end else begin
                presc <= presc + 16'd1;
            end
            // Commons and segments move together, one cycle behind dig_sel
            fnd_com <= dig_sel ? 2'b01 : 2'b10;
            fnd_seg <= seg_next;
        end
    end

endmodule

// File: doc/sec_fnd_drv.md
SEC_FND_DRV -- requirements
Module: sec_fnd_drv

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 16'd50000: clk cycles per display-digit slot; legal range 2..65535.
REQ-002 SHALL have parameter LZ_BLANK, default 1'b0: 1 blanks the tens digit when it is 0.
REQ-003 SHALL have port clk, input, 1: single clock, rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port in_val, input, 6: binary seconds value 0..59 from the upstream mod-60 counter.
REQ-006 SHALL have port bcd_tens, output, 4: registered BCD tens digit.
REQ-007 SHALL have port bcd_ones, output, 4: registered BCD ones digit.
REQ-008 SHALL have port conv_busy, output, 1: conversion in progress.
REQ-009 SHALL have port fnd_seg, output, 7: segments {g,f,e,d,c,b,a}, active-low.
REQ-010 SHALL have port fnd_com, output, 2: digit commons, active-low; bit0 = ones, bit1 = tens.

Function
REQ-011 Conversion FSM SHALL have states IDLE, SHIFT, DONE.
- IDLE: at a clk edge, if in_val != val_q or conv_pend = 1, SHALL capture in_val into val_q and the shift register, clear conv_pend, and go to SHIFT.
REQ-012 SHIFT SHALL run exactly 6 cycles, one shift-add-3 (double-dabble) step per cycle, then go to DONE.
REQ-013 DONE SHALL last 1 cycle, SHALL load bcd_tens/bcd_ones, and SHALL return to IDLE.
REQ-014 Latency SHALL be: capture edge E; bcd outputs valid after edge E+7; conv_busy = 1 exactly in SHIFT and DONE (7 cycles).
REQ-015 in_val changes during SHIFT/DONE SHALL be ignored. The IDLE compare SHALL then start a new conversion on the first IDLE edge if in_val != val_q (1 idle cycle between conversions).
REQ-016 Captured value 60..63 SHALL yield bcd_tens = bcd_ones = 4'hF (out-of-range marker) in DONE.
REQ-017 Scan prescaler SHALL count 0..SCAN_DIV-1 and wrap. At terminal count, digit select SHALL toggle: ones -> tens -> ones.
REQ-018 fnd_com and fnd_seg SHALL be registered together, one cycle after digit select changes.
- Ones slot: fnd_com = 2'b10. Tens slot: fnd_com = 2'b01.
- fnd_com SHALL never be 2'b00.
REQ-019 Segment decode SHALL be:
- 0..9: standard active-low patterns (0 = 7'b1000000, 7 = 7'b1111000).
- 4'hF: dash 7'b0111111.
- Other codes: blank 7'b1111111.
REQ-020 If LZ_BLANK = 1 and bcd_tens = 0, the tens slot SHALL drive fnd_seg = 7'b1111111 with fnd_com still 2'b01.
REQ-021 Display SHALL show the last completed conversion; bcd outputs SHALL be stable during conversion.

Reset
REQ-022 rst = 1 SHALL immediately force:
- bcd_tens = 0, bcd_ones = 0, conv_busy = 0
- fnd_seg = 7'b1111111, fnd_com = 2'b11
- FSM = IDLE, prescaler = 0, digit select = ones
- val_q = 0, conv_pend = 1
REQ-023 rst during SHIFT/DONE SHALL abort the conversion with no partial bcd update.
REQ-024 The first edge after rst release SHALL capture in_val unconditionally (conv_pend = 1).

Structure
REQ-025 A shared package SHALL hold the FSM state encoding, SEG_BLANK, SEG_DASH, the digit segment table and BCD_OOR = 4'hF.
REQ-026 Segment decode SHALL be a combinational sub-module bcd2seg (4-bit in, 7-bit active-low out), instantiated once on the muxed digit.

Verification
REQ-027 Reset release, in_val = 37 -> conv_busy high exactly 7 cycles; after edge E+7, bcd_tens = 3, bcd_ones = 7.
REQ-028 in_val = 12, then 45 at E+3 -> 1/2 after E+7; new capture at E+8; 4/5 after E+15.
REQ-029 in_val 59 -> 0, LZ_BLANK = 1 -> bcd 0/0; tens slot fnd_seg = 7'b1111111; ones slot 7'b1000000.
REQ-030 in_val = 61 -> bcd F/F; both slots fnd_seg = 7'b0111111.
REQ-031 SCAN_DIV = 4 -> fnd_com alternates 2'b10/2'b01 every 4 cycles; never 2'b00; seg matches the active digit in the same cycle.
REQ-032 rst pulse at SHIFT cycle 3 -> all outputs at reset values asynchronously; after release, new capture of in_val and correct result 7 cycles later.
